// File: rtl/sisc_fetch.sv
// SISC instruction-fetch / program-counter unit: owns PC and IR, runs the
// req/ack handshake to instruction memory and resolves branch conditions.
module sisc_fetch #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_rst,
  input  logic          ir_load,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic [3:0]    stat,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic          fetch_busy,
  output logic          ir_valid,
  output logic          br_taken,
  output logic          err
);

  localparam int unsigned OPW = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_ir;
  logic          r_req;
  logic          r_ir_valid;
  logic          r_br_taken;
  logic          r_err;

  logic [OPW-1:0] w_opcode;
  logic [OPW-1:0] w_mm;
  logic [AW-1:0]  w_imm;
  logic [AW-1:0]  w_target;
  logic [AW-1:0]  w_pc_inc;
  logic           w_hit;
  logic           w_taken;

  assign w_opcode = r_ir[DW-1 -: OPW];
  assign w_mm     = r_ir[DW-OPW-1 -: OPW];
  assign w_imm    = r_ir[AW-1:0];
  assign w_target = br_sel ? w_imm : AW'(r_pc + w_imm);
  assign w_pc_inc = AW'(r_pc + AW'(1));
  assign w_hit    = |(w_mm & stat);

  // BRA/BRR take on any selected flag, BNE/BNR on none; everything else jumps
  always_comb begin
    w_taken = 1'b1;
    case (w_opcode)
      OPW'(4), OPW'(5): w_taken = w_hit;
      OPW'(6), OPW'(7): w_taken = ~w_hit;
      default:          w_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= '0;
      r_ir       <= '0;
      r_req      <= 1'b0;
      r_ir_valid <= 1'b0;
      r_br_taken <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      r_br_taken <= 1'b0;
      if (pc_rst) begin
        // abort: any ack in this cycle is dropped and IR is left alone
        r_state <= S_IDLE;
        r_req   <= 1'b0;
        r_pc    <= RESET_PC;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ir_load) begin
              r_addr  <= r_pc;
              r_req   <= 1'b1;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ir_load) begin
              r_err <= 1'b1;
            end
            if (imem_ack) begin
              r_ir       <= imem_rdata;
              r_ir_valid <= 1'b1;
              r_req      <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        endcase

        // PC runs independently of the fetch; the fetch address is already latched
        if (pc_write) begin
          if (!pc_sel) begin
            r_pc <= w_pc_inc;
          end else if (w_taken) begin
            r_pc       <= w_target;
            r_br_taken <= 1'b1;
          end
        end
      end
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign fetch_busy = r_req;
  assign ir_valid   = r_ir_valid;
  assign br_taken   = r_br_taken;
  assign err        = r_err;

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed scenarios with literal expectations, then a
// randomized run, all checked every cycle against a transaction-level model.
module tb_sisc_fetch;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam logic [AW-1:0] RESET_PC = 16'h0000;

  logic          clk;
  logic          rst, pc_rst, ir_load, pc_write, pc_sel, br_sel, imem_ack;
  logic [3:0]    stat;
  logic [DW-1:0] imem_rdata;
  logic          imem_req, fetch_busy, ir_valid, br_taken, err;
  logic [AW-1:0] imem_addr, pc;
  logic [DW-1:0] ir;

  int errors = 0;
  int checks = 0;

  sisc_fetch #(.AW(AW), .DW(DW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc_rst(pc_rst), .ir_load(ir_load),
    .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel), .stat(stat),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .ir(ir),
    .fetch_busy(fetch_busy), .ir_valid(ir_valid), .br_taken(br_taken), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit          valid;
    bit          busy;
    bit          irv;
    bit          brt;
    bit          err;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [31:0] ir;
  } ms_t;

  ms_t m = '0;

  function automatic bit branch_taken(input logic [31:0] instr, input logic [3:0] st);
    int opc;
    bit any;
    opc = int'(instr[31:28]);
    any = (instr[27:24] & st) != 4'h0;
    if (opc == 4 || opc == 5) return any;
    if (opc == 6 || opc == 7) return !any;
    return 1'b1;
  endfunction

  function automatic ms_t step(input ms_t s, input bit r, input bit prst, input bit ld,
                               input bit pw, input bit psel, input bit bsel,
                               input logic [3:0] st, input bit ack, input logic [31:0] rd);
    ms_t n;
    int  imm, target;
    n = s;
    n.irv = 1'b0;
    n.brt = 1'b0;
    if (r) begin
      n = '0;
      n.valid = 1'b1;
      n.pc = RESET_PC;
      return n;
    end
    if (prst) begin
      n.pc = RESET_PC;
      n.busy = 1'b0;
      return n;
    end
    imm = int'(s.ir[15:0]);
    target = bsel ? imm : (int'(s.pc) + imm) % 65536;
    if (pw) begin
      if (!psel) n.pc = 16'((int'(s.pc) + 1) % 65536);
      else if (branch_taken(s.ir, st)) begin
        n.pc = 16'(target);
        n.brt = 1'b1;
      end
    end
    if (!s.busy) begin
      if (ld) begin
        n.addr = s.pc;
        n.busy = 1'b1;
      end
    end else begin
      if (ld) n.err = 1'b1;
      if (ack) begin
        n.ir = rd;
        n.irv = 1'b1;
        n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m, rst, pc_rst, ir_load, pc_write, pc_sel, br_sel, stat, imem_ack, imem_rdata);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    if (m.valid) begin
      chk("pc",         32'(pc),         32'(m.pc));
      chk("ir",         ir,              m.ir);
      chk("imem_addr",  32'(imem_addr),  32'(m.addr));
      chk("imem_req",   32'(imem_req),   32'(m.busy));
      chk("fetch_busy", 32'(fetch_busy), 32'(m.busy));
      chk("ir_valid",   32'(ir_valid),   32'(m.irv));
      chk("br_taken",   32'(br_taken),   32'(m.brt));
      chk("err",        32'(err),        32'(m.err));
    end
  endtask

  // one clock: inputs apply at the rising edge, outputs compared on the falling edge
  task automatic tick();
    @(negedge clk);
    compare_model();
  endtask

  task automatic clear_in();
    rst = 0; pc_rst = 0; ir_load = 0; pc_write = 0; pc_sel = 0; br_sel = 0;
    imem_ack = 0;
  endtask

  task automatic fetch(input logic [31:0] d, input int lat);
    ir_load = 1; tick(); ir_load = 0;
    repeat (lat) tick();
    imem_ack = 1; imem_rdata = d; tick(); imem_ack = 0;
    chk("fetch_ir", ir, d);
  endtask

  task automatic branch(input bit abs_sel);
    pc_write = 1; pc_sel = 1; br_sel = abs_sel; tick(); clear_in();
  endtask

  initial begin
    logic [31:0] word;
    clear_in();
    stat = 4'h0; imem_rdata = '0;
    rst = 1; tick(); tick(); rst = 0;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // reset and fetch with concurrent PC+1
    ir_load = 1; pc_write = 1; pc_sel = 0; tick(); clear_in();
    chk("t1_addr", 32'(imem_addr), 32'h0);
    chk("t1_req", 32'(imem_req), 32'h1);
    chk("t1_pc", 32'(pc), 32'h1);
    tick(); tick();
    imem_ack = 1; imem_rdata = 32'h5F00_0004; tick(); imem_ack = 0;
    chk("t1_ir", ir, 32'h5F00_0004);
    chk("t1_irv", 32'(ir_valid), 32'h1);
    chk("t1_req_drop", 32'(imem_req), 32'h0);
    tick();
    chk("t1_irv_pulse", 32'(ir_valid), 32'h0);

    // set PC to 0x0010 via an unconditional absolute jump
    fetch(32'h0000_0010, 1);
    branch(1'b1);
    chk("jmp_pc", 32'(pc), 32'h10);
    chk("jmp_brt", 32'(br_taken), 32'h1);
    tick();
    chk("jmp_brt_pulse", 32'(br_taken), 32'h0);

    // relative BRR taken: 0x10 + 5
    fetch(32'h5200_0005, 0);
    stat = 4'h2; branch(1'b0);
    chk("brr_pc", 32'(pc), 32'h15);
    chk("brr_brt", 32'(br_taken), 32'h1);

    // BNE not taken, then taken absolute
    fetch(32'h6200_00A0, 2);
    stat = 4'h2; branch(1'b1);
    chk("bne_nt_pc", 32'(pc), 32'h15);
    chk("bne_nt_brt", 32'(br_taken), 32'h0);
    stat = 4'h0; branch(1'b1);
    chk("bne_t_pc", 32'(pc), 32'hA0);

    // relative wrap: 0xFFFE + 3 -> 0x0001
    fetch(32'h0000_FFFE, 0);
    branch(1'b1);
    chk("wrap_pre", 32'(pc), 32'hFFFE);
    fetch(32'h0000_0003, 0);
    branch(1'b0);
    chk("wrap_pc", 32'(pc), 32'h0001);

    // abort with a coincident ack, then a stray ack
    ir_load = 1; tick(); ir_load = 0; tick();
    pc_rst = 1; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; tick(); clear_in();
    chk("abort_req", 32'(imem_req), 32'h0);
    chk("abort_pc", 32'(pc), 32'(RESET_PC));
    chk("abort_ir", ir, 32'h0000_0003);
    chk("abort_irv", 32'(ir_valid), 32'h0);
    imem_ack = 1; imem_rdata = 32'hCAFE_F00D; tick(); clear_in();
    chk("stray_ir", ir, 32'h0000_0003);
    chk("stray_irv", 32'(ir_valid), 32'h0);

    // protocol error: second ir_load while busy
    pc_write = 1; tick(); tick(); clear_in();
    ir_load = 1; tick(); clear_in();
    pc_write = 1; tick(); clear_in();
    ir_load = 1; tick(); clear_in();
    chk("perr_addr", 32'(imem_addr), 32'h2);
    chk("perr_err", 32'(err), 32'h1);
    imem_ack = 1; imem_rdata = 32'h1234_5678; tick(); clear_in();
    pc_rst = 1; tick(); clear_in(); tick();
    chk("perr_sticky", 32'(err), 32'h1);
    rst = 1; tick(); clear_in();
    chk("perr_clr", 32'(err), 32'h0);

    // back-to-back zero-wait fetches of addresses 0..3
    for (int i = 0; i < 4; i++) begin
      ir_load = 1; pc_write = 1; pc_sel = 0; tick(); clear_in();
      chk("b2b_addr", 32'(imem_addr), 32'(i));
      word = 32'hA500_0000 | 32'(i);
      imem_ack = 1; imem_rdata = word; tick(); clear_in();
      chk("b2b_ir", ir, word);
      chk("b2b_err", 32'(err), 32'h0);
    end

    // randomized traffic with a random-latency memory and occasional stray acks
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      pc_rst   = ($urandom_range(0, 39) == 0);
      ir_load  = ($urandom_range(0, 2) == 0);
      pc_write = ($urandom_range(0, 1) == 0);
      pc_sel   = 1'($urandom_range(0, 1));
      br_sel   = 1'($urandom_range(0, 1));
      stat     = 4'($urandom_range(0, 15));
      if (imem_req) imem_ack = ($urandom_range(0, 2) == 0);
      else          imem_ack = ($urandom_range(0, 9) == 0);
      imem_rdata = $urandom;
      tick();
    end
    clear_in();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
